pe_rr_arbiter: RTL and testbench

Eight-way request arbiter built around the priority-encode function. It shares one downstream resource among eight requesters and issues a registered one-hot grant plus its 3-bit encoded index. Two policies are supported: fixed priority (highest index wins) and round-robin. A hold limit forces release so that no requester can keep the resource indefinitely.

---
 rtl/pe_rr_arbiter_if.sv | 28 ++
 rtl/pe_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_pe_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the shared-resource arbiter.
// The requester side drives req/rr_mode; the arbiter returns the registered grant.
interface pe_rr_arbiter_if;
   logic [7:0] req;
   logic       rr_mode;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output req,
      output rr_mode,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  rr_mode,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );
endinterface

// File: rtl/pe_rr_arbiter.sv
// Eight-way fixed-priority / round-robin arbiter with a registered one-hot grant
// and a hold limit that forces release after MAX_HOLD consecutive cycles.
//
//   state | meaning
//   IDLE  | no grant held; arbitrate over req on every edge
//   GRANT | grant held by gnt_idx; release on req drop or hold limit
module pe_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic           clk,
   input  logic           rst,
   pe_rr_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] ptr, ptr_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic [7:0] gnt_q, gnt_nxt;
   logic [2:0] idx_q, idx_nxt;
   logic       valid_q, valid_nxt;
   logic       tmo_q, tmo_nxt;

   logic [7:0] cand;
   logic [2:0] pos;
   logic [2:0] win;
   logic       found;
   logic       holder_req;
   logic       hold_max;

   assign holder_req = |(bus.req & gnt_q);
   assign hold_max   = (hold_cnt == 8'(MAX_HOLD));

   // The current holder is masked from the search so it is never re-granted back-to-back.
   always_comb begin
      cand  = (state == GRANT) ? (bus.req & ~gnt_q) : bus.req;
      win   = 3'd0;
      found = 1'b0;
      pos   = 3'd0;
      for (int j = 0; j < 8; j++) begin
         pos = bus.rr_mode ? (ptr - 3'd1 - 3'(j)) : (3'd7 - 3'(j));
         if (!found && cand[pos]) begin
            win   = pos;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      gnt_nxt   = gnt_q;
      idx_nxt   = idx_q;
      valid_nxt = valid_q;
      tmo_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = GRANT;
               ptr_nxt   = win;
               hold_nxt  = 8'd1;
               gnt_nxt   = 8'h01 << win;
               idx_nxt   = win;
               valid_nxt = 1'b1;
            end
         end
         GRANT: begin
            if (!holder_req || hold_max) begin
               // A holder still requesting at this point was cut off by the limit.
               tmo_nxt = holder_req;
               if (found) begin
                  ptr_nxt   = win;
                  hold_nxt  = 8'd1;
                  gnt_nxt   = 8'h01 << win;
                  idx_nxt   = win;
                  valid_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  hold_nxt  = 8'd0;
                  gnt_nxt   = 8'h00;
                  idx_nxt   = 3'd0;
                  valid_nxt = 1'b0;
               end
            end else begin
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         hold_cnt <= 8'd0;
         gnt_q    <= 8'h00;
         idx_q    <= 3'd0;
         valid_q  <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         gnt_q    <= gnt_nxt;
         idx_q    <= idx_nxt;
         valid_q  <= valid_nxt;
         tmo_q    <= tmo_nxt;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid_q;
   assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_pe_rr_arbiter.sv
// Bench for pe_rr_arbiter: two instances (hold limit 4 and 1) share one request
// stream and are checked against a queue-free per-requester reference model.
module tb_pe_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       rr_mode;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pe_rr_arbiter_if bus4 ();
   pe_rr_arbiter_if bus1 ();

   assign bus4.req     = req;
   assign bus4.rr_mode = rr_mode;
   assign bus1.req     = req;
   assign bus1.rr_mode = rr_mode;

   pe_rr_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   pe_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Model state per instance: holder (-1 = none), tenure length, last winner.
   int m_holder [2];
   int m_cnt    [2];
   int m_ptr    [2];
   bit m_tmo    [2];
   int m_max    [2] = '{4, 1};

   typedef struct {
      logic [7:0] req;
      logic [2:0] idx;
   } vec_t;

   vec_t tbl [10];

   function automatic int arb(logic [7:0] cand, logic mode, int p);
      int i;
      if (!mode) begin
         for (int k = 7; k >= 0; k--)
            if (cand[k]) return k;
      end else begin
         for (int k = 1; k <= 8; k++) begin
            i = (p - k + 16) % 8;
            if (cand[i]) return i;
         end
      end
      return -1;
   endfunction

   task automatic model_step(input int k);
      int  w;
      bit  vol;
      bit  forced;
      if (rst) begin
         m_holder[k] = -1;
         m_cnt[k]    = 0;
         m_ptr[k]    = 0;
         m_tmo[k]    = 1'b0;
      end else if (m_holder[k] < 0) begin
         m_tmo[k] = 1'b0;
         w = arb(req, rr_mode, m_ptr[k]);
         if (w >= 0) begin
            m_holder[k] = w;
            m_cnt[k]    = 1;
            m_ptr[k]    = w;
         end
      end else begin
         vol    = !req[m_holder[k]];
         forced = !vol && (m_cnt[k] == m_max[k]);
         if (vol || forced) begin
            w = arb(req & ~(8'h01 << m_holder[k]), rr_mode, m_ptr[k]);
            m_tmo[k] = forced;
            if (w >= 0) begin
               m_holder[k] = w;
               m_cnt[k]    = 1;
               m_ptr[k]    = w;
            end else begin
               m_holder[k] = -1;
               m_cnt[k]    = 0;
            end
         end else begin
            m_cnt[k] = m_cnt[k] + 1;
            m_tmo[k] = 1'b0;
         end
      end
   endtask

   function automatic logic [12:0] get_out(int k);
      if (k == 0) return {bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.timeout};
      return {bus1.gnt, bus1.gnt_idx, bus1.gnt_valid, bus1.timeout};
   endfunction

   function automatic logic [12:0] model_out(int k);
      logic [12:0] o;
      if (m_holder[k] < 0) o = {8'h00, 3'd0, 1'b0, m_tmo[k]};
      else o = {8'(8'h01 << m_holder[k]), 3'(m_holder[k]), 1'b1, m_tmo[k]};
      return o;
   endfunction

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_eq({tag, "_model_h4"}, 32'(get_out(0)), 32'(model_out(0)));
      check_eq({tag, "_model_h1"}, 32'(get_out(1)), 32'(model_out(1)));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick("rst");
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) begin
         tbl[i].req = 8'h01 << i;
         tbl[i].idx = 3'(i);
      end
      tbl[8] = '{8'b1100_1000, 3'd7};
      tbl[9] = '{8'b0010_0111, 3'd5};

      // reset with every requester asserted, then idle
      rst = 1'b1; req = 8'hFF; rr_mode = 1'b0;
      tick("reset");
      tick("reset");
      check_eq("reset_outputs", 32'(get_out(0)), 32'h0);
      rst = 1'b0; req = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick("idle");
         check_eq("idle_outputs", 32'(get_out(0)), 32'h0);
      end

      // fixed-priority encode, one tenure each, back through IDLE
      for (int i = 0; i < 10; i++) begin
         req = tbl[i].req;
         tick("fixed");
         check_eq("fixed_idx", 32'(bus4.gnt_idx), 32'(tbl[i].idx));
         check_eq("fixed_gnt", 32'(bus4.gnt), 32'(8'h01 << tbl[i].idx));
         req = 8'h00;
         tick("fixed_rel");
         check_eq("fixed_release", 32'(get_out(0)), 32'h0);
         tick("fixed_gap");
      end

      // round-robin rotation under the hold limit
      do_reset();
      rr_mode = 1'b1; req = 8'hFF;
      for (int t = 0; t < 9; t++) begin
         for (int c = 0; c < 4; c++) begin
            tick("rr");
            check_eq("rr_idx", 32'(bus4.gnt_idx), 32'(7 - (t % 8)));
            check_eq("rr_valid", 32'(bus4.gnt_valid), 32'd1);
            check_eq("rr_timeout", 32'(bus4.timeout), 32'((c == 0) && (t > 0)));
         end
      end

      // fixed mode: the top two requesters alternate on timeout
      do_reset();
      rr_mode = 1'b0; req = 8'hFF;
      for (int t = 0; t < 4; t++) begin
         for (int c = 0; c < 4; c++) begin
            tick("fx_tmo");
            check_eq("fx_tmo_idx", 32'(bus4.gnt_idx), (t % 2) ? 32'd6 : 32'd7);
            check_eq("fx_tmo_pulse", 32'(bus4.timeout), 32'((c == 0) && (t > 0)));
         end
      end

      // voluntary release with direct handover, then to IDLE
      do_reset();
      req = 8'b1000_0100;
      tick("vol");
      check_eq("vol_first", 32'(bus4.gnt_idx), 32'd7);
      tick("vol");
      req = 8'b0000_0100;
      tick("vol");
      check_eq("vol_handover_gnt", 32'(bus4.gnt), 32'h04);
      check_eq("vol_handover_tmo", 32'(bus4.timeout), 32'd0);
      req = 8'h00;
      tick("vol");
      check_eq("vol_idle", 32'(get_out(0)), 32'h0);

      // drop on the same edge the limit is reached counts as voluntary
      do_reset();
      req = 8'hFF;
      for (int i = 0; i < 4; i++) tick("edge");
      req = 8'h7F;
      tick("edge");
      check_eq("edge_idx", 32'(bus4.gnt_idx), 32'd6);
      check_eq("edge_tmo", 32'(bus4.timeout), 32'd0);

      // reset mid-tenure restores the round-robin pointer
      do_reset();
      rr_mode = 1'b1; req = 8'b0000_1000;
      tick("midrst");
      check_eq("midrst_grant", 32'(bus4.gnt_idx), 32'd3);
      tick("midrst");
      rst = 1'b1;
      tick("midrst");
      check_eq("midrst_zero", 32'(get_out(0)), 32'h0);
      rst = 1'b0; req = 8'b0000_1001;
      tick("midrst");
      check_eq("midrst_ptr", 32'(bus4.gnt_idx), 32'd3);

      // random traffic against the model on both instances
      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 3))
            0: req = 8'($urandom);
            1: req = 8'($urandom) & 8'($urandom);
            2: req = req;
            default: req = req & 8'($urandom);
         endcase
         if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
         rst = ($urandom_range(0, 99) == 0);
         tick("rand");
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
